serial_word_comparator: RTL and testbench



---
 rtl/serial_cmp_pkg.sv | 64 ++++++
 rtl/serial_word_comparator_if.sv | 26 ++
 rtl/serial_cmp_digit.sv | 35 +++
 rtl/serial_word_comparator.sv | 119 +++++++++++
 tb/tb_serial_word_comparator.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the serial word comparator.
//   state_t   : FSM states (idle + three in-progress provisional decisions)
//   cmp_t     : per-digit / per-word comparison outcome
//   verdict_t : registered {lt, eq, gt} result payload
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EQ   = 2'd1,
        ST_LT   = 2'd2,
        ST_GT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } verdict_t;

    localparam verdict_t VERDICT_RST = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

    // One-hot verdict for a comparison outcome.
    function automatic verdict_t cmp_to_verdict(input cmp_t c);
        verdict_t v;
        v = VERDICT_RST;
        case (c)
            CMP_LT:  v = '{lt: 1'b1, eq: 1'b0, gt: 1'b0};
            CMP_GT:  v = '{lt: 1'b0, eq: 1'b0, gt: 1'b1};
            default: v = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};
        endcase
        return v;
    endfunction

    // In-progress state holding a provisional decision.
    function automatic state_t cmp_to_state(input cmp_t c);
        state_t s;
        s = ST_EQ;
        case (c)
            CMP_LT:  s = ST_LT;
            CMP_GT:  s = ST_GT;
            default: s = ST_EQ;
        endcase
        return s;
    endfunction

    // Provisional decision carried by a state; idle counts as equal.
    function automatic cmp_t state_to_cmp(input state_t s);
        cmp_t c;
        c = CMP_EQ;
        case (s)
            ST_LT:   c = CMP_LT;
            ST_GT:   c = CMP_GT;
            default: c = CMP_EQ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/serial_word_comparator_if.sv
// Digit stream in / verdict out bundle of the serial word comparator.
//   master : drives start, valid, a_dig, b_dig; observes busy and the verdict
//   slave  : the comparator side
interface serial_word_comparator_if #(
    parameter int unsigned DIGIT_W = 1
);
    logic               start;
    logic               valid;
    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic               busy;
    logic               res_valid;
    logic               a_less_b;
    logic               a_eq_b;
    logic               a_greater_b;

    modport master (
        output start, valid, a_dig, b_dig,
        input  busy, res_valid, a_less_b, a_eq_b, a_greater_b
    );

    modport slave (
        input  start, valid, a_dig, b_dig,
        output busy, res_valid, a_less_b, a_eq_b, a_greater_b
    );
endinterface

// File: rtl/serial_cmp_digit.sv
// Combinational compare of one digit pair.
//   a_dig, b_dig : digits of A and B
//   msd_signed   : digit is the most significant one of a two's-complement word
//   cmp_c        : A digit vs B digit
module serial_cmp_digit
    import serial_cmp_pkg::*;
#(
    parameter int unsigned DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a_dig,
    input  logic [DIGIT_W-1:0] b_dig,
    input  logic               msd_signed,
    output cmp_t               cmp_c
);

    logic [DIGIT_W-1:0] a_m;
    logic [DIGIT_W-1:0] b_m;

    // Flipping the sign bit maps two's complement order onto unsigned order.
    always_comb begin
        a_m = a_dig;
        b_m = b_dig;
        if (msd_signed) begin
            a_m[DIGIT_W-1] = ~a_dig[DIGIT_W-1];
            b_m[DIGIT_W-1] = ~b_dig[DIGIT_W-1];
        end
        cmp_c = CMP_EQ;
        if (a_m < b_m) begin
            cmp_c = CMP_LT;
        end else if (a_m > b_m) begin
            cmp_c = CMP_GT;
        end
    end

endmodule

// File: rtl/serial_word_comparator.sv
// Serial magnitude comparator for framed words of WORD_W/DIGIT_W digits.
//   clk, rst : clock (rising edge), asynchronous active-low reset
//   bus      : start/valid/a_dig/b_dig in; busy, res_valid and held
//              a_less_b/a_eq_b/a_greater_b verdict out (all registered)
module serial_word_comparator
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned DIGIT_W   = 1,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned SIGNED    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_word_comparator_if.slave  bus
);

    localparam int unsigned NDIG  = WORD_W / DIGIT_W;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NDIG - 1);

    if ((WORD_W % DIGIT_W) != 0) begin : g_bad_width
        $error("serial_word_comparator: WORD_W must be a multiple of DIGIT_W");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    verdict_t         verdict_q, verdict_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    logic             accept_c;
    logic [CNT_W-1:0] idx_c;
    logic             last_c;
    logic             msd_signed_c;
    cmp_t             dig_cmp_c;
    cmp_t             prov_c;
    cmp_t             new_c;

    // Position of the digit on the bus; a start always restarts at digit 0.
    always_comb begin
        accept_c     = bus.valid && (bus.start || (state_q != ST_IDLE));
        idx_c        = bus.start ? '0 : cnt_q;
        last_c       = (idx_c == LAST_IDX);
        msd_signed_c = 1'b0;
        if (SIGNED != 0) begin
            msd_signed_c = (MSB_FIRST != 0) ? (idx_c == '0) : last_c;
        end
    end

    serial_cmp_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .a_dig      (bus.a_dig),
        .b_dig      (bus.b_dig),
        .msd_signed (msd_signed_c),
        .cmp_c      (dig_cmp_c)
    );

    // Next state: fold the digit into the provisional decision, retire on the last digit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        verdict_d   = verdict_q;
        res_valid_d = 1'b0;
        busy_d      = busy_q;
        prov_c      = bus.start ? CMP_EQ : state_to_cmp(state_q);
        new_c       = prov_c;

        if (MSB_FIRST != 0) begin
            // Most significant difference arrives first and wins.
            if (prov_c == CMP_EQ) begin
                new_c = dig_cmp_c;
            end
        end else begin
            // Later digits are more significant, so any difference overrides.
            if (dig_cmp_c != CMP_EQ) begin
                new_c = dig_cmp_c;
            end
        end

        if (accept_c) begin
            if (last_c) begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                verdict_d   = cmp_to_verdict(new_c);
                res_valid_d = 1'b1;
                busy_d      = 1'b0;
            end else begin
                state_d     = cmp_to_state(new_c);
                cnt_d       = idx_c + CNT_W'(1);
                busy_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            verdict_q   <= VERDICT_RST;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            verdict_q   <= verdict_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.a_less_b    = verdict_q.lt;
    assign bus.a_eq_b      = verdict_q.eq;
    assign bus.a_greater_b = verdict_q.gt;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Bench for serial_word_comparator: four configurations side by side
//   dut0: 16b, 1b digits, MSB first, unsigned
//   dut1: 16b, 1b digits, LSB first, unsigned
//   dut2: 16b, 4b digits, MSB first, signed
//   dut3: 16b, 4b digits, MSB first, unsigned
// Expected verdicts are queued when the last digit is driven and popped on res_valid.
module tb_serial_word_comparator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_word_comparator_if #(.DIGIT_W(1)) if0 ();
    serial_word_comparator_if #(.DIGIT_W(1)) if1 ();
    serial_word_comparator_if #(.DIGIT_W(4)) if2 ();
    serial_word_comparator_if #(.DIGIT_W(4)) if3 ();

    serial_word_comparator #(.WORD_W(16), .DIGIT_W(1), .MSB_FIRST(1), .SIGNED(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    serial_word_comparator #(.WORD_W(16), .DIGIT_W(1), .MSB_FIRST(0), .SIGNED(0))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    serial_word_comparator #(.WORD_W(16), .DIGIT_W(4), .MSB_FIRST(1), .SIGNED(1))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    serial_word_comparator #(.WORD_W(16), .DIGIT_W(4), .MSB_FIRST(1), .SIGNED(0))
        u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    logic [3:0] st_v;
    logic [3:0] vl_v;
    logic [3:0] ad [4];
    logic [3:0] bd [4];
    logic [3:0] bz;
    logic [3:0] rv;
    logic [2:0] vd [4];

    assign if0.start = st_v[0]; assign if0.valid = vl_v[0];
    assign if1.start = st_v[1]; assign if1.valid = vl_v[1];
    assign if2.start = st_v[2]; assign if2.valid = vl_v[2];
    assign if3.start = st_v[3]; assign if3.valid = vl_v[3];
    assign if0.a_dig = ad[0][0:0]; assign if0.b_dig = bd[0][0:0];
    assign if1.a_dig = ad[1][0:0]; assign if1.b_dig = bd[1][0:0];
    assign if2.a_dig = ad[2];      assign if2.b_dig = bd[2];
    assign if3.a_dig = ad[3];      assign if3.b_dig = bd[3];

    assign bz = {if3.busy, if2.busy, if1.busy, if0.busy};
    assign rv = {if3.res_valid, if2.res_valid, if1.res_valid, if0.res_valid};
    assign vd[0] = {if0.a_less_b, if0.a_eq_b, if0.a_greater_b};
    assign vd[1] = {if1.a_less_b, if1.a_eq_b, if1.a_greater_b};
    assign vd[2] = {if2.a_less_b, if2.a_eq_b, if2.a_greater_b};
    assign vd[3] = {if3.a_less_b, if3.a_eq_b, if3.a_greater_b};

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] sbq [4][$];
    logic [2:0] last_exp [4];

    localparam logic [2:0] V_LT = 3'b100;
    localparam logic [2:0] V_EQ = 3'b010;
    localparam logic [2:0] V_GT = 3'b001;

    function automatic int dw(input int id);
        return (id < 2) ? 1 : 4;
    endfunction

    function automatic bit msbf(input int id);
        return id != 1;
    endfunction

    function automatic bit sgn(input int id);
        return id == 2;
    endfunction

    // Reference verdict from whole-word integer comparison.
    function automatic logic [2:0] exp_cmp(input logic [15:0] a, input logic [15:0] b, input bit s);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = a;
        sb = b;
        if (s) begin
            if (sa < sb) return V_LT;
            if (sa > sb) return V_GT;
            return V_EQ;
        end
        if (a < b) return V_LT;
        if (a > b) return V_GT;
        return V_EQ;
    endfunction

    function automatic logic [3:0] get_digit(input int id, input logic [15:0] w, input int k);
        int nd;
        int pos;
        logic [15:0] sh;
        nd  = 16 / dw(id);
        pos = msbf(id) ? (nd - 1 - k) : k;
        sh  = w >> (pos * dw(id));
        return (dw(id) == 1) ? {3'b000, sh[0]} : sh[3:0];
    endfunction

    // Scoreboard: every res_valid pulse must match the oldest queued verdict.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst === 1'b1 && rv[i] === 1'b1) begin
                n_cmp++;
                if (sbq[i].size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected dut%0d: res_valid with verdict %b, none expected", i, vd[i]);
                end else begin
                    logic [2:0] e;
                    e = sbq[i].pop_front();
                    if (vd[i] !== e) begin
                        n_bad++;
                        $display("FAIL sb_verdict dut%0d: got lt/eq/gt=%b, want %b", i, vd[i], e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int id, input logic s, input logic v, input logic [3:0] a, input logic [3:0] b);
        st_v[id] = s;
        vl_v[id] = v;
        ad[id]   = a;
        bd[id]   = b;
    endtask

    task automatic send_word(input int id, input logic [15:0] a, input logic [15:0] b,
                             input int gap_after, input int gap_len, input bit idle_after);
        int nd;
        logic [2:0] e;
        nd = 16 / dw(id);
        e  = exp_cmp(a, b, sgn(id));
        for (int k = 0; k < nd; k++) begin
            set_in(id, k == 0, 1'b1, get_digit(id, a, k), get_digit(id, b, k));
            if (k == nd - 1) sbq[id].push_back(e);
            step();
            n_cmp++;
            if (k < nd - 1) begin
                if (bz[id] !== 1'b1 || rv[id] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_mid dut%0d digit %0d: busy=%b res_valid=%b, want 1/0", id, k, bz[id], rv[id]);
                end
                if (k == gap_after) begin
                    for (int g = 0; g < gap_len; g++) begin
                        set_in(id, 1'b0, 1'b0, 4'h0, 4'h0);
                        step();
                        n_cmp++;
                        if (bz[id] !== 1'b1 || rv[id] !== 1'b0) begin
                            n_bad++;
                            $display("FAIL gap dut%0d cycle %0d: busy=%b res_valid=%b, want 1/0", id, g, bz[id], rv[id]);
                        end
                    end
                end
            end else if (rv[id] !== 1'b1 || bz[id] !== 1'b0) begin
                n_bad++;
                $display("FAIL res_latency dut%0d: res_valid=%b busy=%b, want 1/0", id, rv[id], bz[id]);
            end
        end
        last_exp[id] = e;
        if (idle_after) begin
            set_in(id, 1'b0, 1'b0, 4'h0, 4'h0);
            step();
            n_cmp++;
            if (rv[id] !== 1'b0 || vd[id] !== e) begin
                n_bad++;
                $display("FAIL hold dut%0d: res_valid=%b verdict=%b, want 0/%b", id, rv[id], vd[id], e);
            end
        end
    endtask

    // Drives the first n digits of a word that is never finished.
    task automatic send_partial(input int id, input logic [15:0] a, input logic [15:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            set_in(id, k == 0, 1'b1, get_digit(id, a, k), get_digit(id, b, k));
            step();
            n_cmp++;
            if (bz[id] !== 1'b1 || rv[id] !== 1'b0 || vd[id] !== last_exp[id]) begin
                n_bad++;
                $display("FAIL partial dut%0d digit %0d: busy=%b res_valid=%b verdict=%b, want 1/0/%b",
                         id, k, bz[id], rv[id], vd[id], last_exp[id]);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(i, 1'b0, 1'b0, 4'h0, 4'h0);
            last_exp[i] = V_EQ;
        end
        rst = 1'b1;
        #1 rst = 1'b0;
        #3;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bz[i] !== 1'b0 || rv[i] !== 1'b0 || vd[i] !== V_EQ) begin
                n_bad++;
                $display("FAIL reset_vals dut%0d: busy=%b res_valid=%b verdict=%b, want 0/0/010", i, bz[i], rv[i], vd[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_msb_first_bits();
        send_word(0, 16'h6482, 16'h6262, -1, 0, 1'b1);
        repeat (3) begin
            step();
            n_cmp++;
            if (vd[0] !== V_GT || rv[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL msb_hold: verdict=%b res_valid=%b, want 001/0", vd[0], rv[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        send_word(1, 16'h6482, 16'h6262, -1, 0, 1'b0);
        send_word(1, 16'h6262, 16'h6482, -1, 0, 1'b1);
    endtask

    task automatic test_signed_digits();
        send_word(2, 16'h8000, 16'h0001, -1, 0, 1'b1);
        send_word(3, 16'h8000, 16'h0001, -1, 0, 1'b1);
        send_word(2, 16'hFFFF, 16'hFFFF, -1, 0, 1'b1);
        send_word(3, 16'hFFFF, 16'hFFFF, -1, 0, 1'b1);
        send_word(2, 16'h7FFF, 16'hFFFE, -1, 0, 1'b1);
    endtask

    task automatic test_gap();
        send_word(3, 16'hA5C3, 16'hA5C7, 1, 3, 1'b1);
    endtask

    task automatic test_idle_valid();
        for (int c = 0; c < 3; c++) begin
            set_in(2, 1'b0, 1'b1, 4'hF, 4'h0);
            step();
            n_cmp++;
            if (bz[2] !== 1'b0 || rv[2] !== 1'b0 || vd[2] !== last_exp[2]) begin
                n_bad++;
                $display("FAIL idle_valid cycle %0d: busy=%b res_valid=%b verdict=%b, want 0/0/%b",
                         c, bz[2], rv[2], vd[2], last_exp[2]);
            end
        end
        set_in(2, 1'b0, 1'b0, 4'h0, 4'h0);
        send_word(2, 16'h0010, 16'h0100, -1, 0, 1'b1);
    endtask

    task automatic test_abort();
        send_partial(3, 16'h1234, 16'h1200, 3);
        send_word(3, 16'h0005, 16'h0007, -1, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        send_partial(0, 16'hF00F, 16'h0FF0, 9);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (bz[0] !== 1'b0 || rv[0] !== 1'b0 || vd[0] !== V_EQ) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%b res_valid=%b verdict=%b, want 0/0/010", bz[0], rv[0], vd[0]);
        end
        for (int i = 0; i < 4; i++) last_exp[i] = V_EQ;
        set_in(0, 1'b0, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        send_word(0, 16'h1234, 16'h1235, -1, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            int id;
            logic [15:0] a;
            logic [15:0] b;
            id = int'($urandom_range(0, 3));
            a  = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ 16'(1 << $urandom_range(0, 15));
                default: b = 16'($urandom);
            endcase
            send_word(id, a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_msb_first_bits();
        test_back_to_back();
        test_signed_digits();
        test_gap();
        test_idle_valid();
        test_abort();
        test_reset_mid();
        test_random();
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (sbq[i].size() != 0) begin
                n_bad++;
                $display("FAIL sb_pending dut%0d: %0d verdicts never produced, want 0", i, sbq[i].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
